// File: rtl/camera_follow.sv
// camera_follow: once per frame, eases the viewport origin toward the car with a deadzone and clamps it to the world.
// Ports:
//   clk_in, rst_in              clock and asynchronous active-low reset
//   nf_in                       new-frame pulse; starts an update when idle
//   target_x_in, target_y_in    car centre in unsigned world coordinates
//   snap_in, freeze_in          jump to target / hold camera (sampled at capture)
//   camera_x_out, camera_y_out  committed viewport origin
//   valid_out                   one-cycle pulse when both axes commit together
//   busy_out                    high while an update is in progress
module camera_follow #(
    parameter int WORLD_W  = 4096,
    parameter int WORLD_H  = 4096,
    parameter int SCREEN_W = 1280,
    parameter int SCREEN_H = 720,
    parameter int DEADZONE = 64,
    parameter int SHIFT    = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        nf_in,
    input  logic [31:0] target_x_in,
    input  logic [31:0] target_y_in,
    input  logic        snap_in,
    input  logic        freeze_in,
    output logic [31:0] camera_x_out,
    output logic [31:0] camera_y_out,
    output logic        valid_out,
    output logic        busy_out
);
    typedef enum logic [2:0] {IDLE, CAPTURE, AXIS_X, AXIS_Y, COMMIT} state_t;

    localparam logic signed [33:0] HALF_W = 34'(SCREEN_W / 2);
    localparam logic signed [33:0] HALF_H = 34'(SCREEN_H / 2);
    localparam logic signed [33:0] MAX_X  = 34'(WORLD_W - SCREEN_W);
    localparam logic signed [33:0] MAX_Y  = 34'(WORLD_H - SCREEN_H);
    localparam logic signed [33:0] DZ     = 34'(DEADZONE);

    state_t            state_q, state_d;
    logic [31:0]       tx_q, ty_q, hold_x_q, hold_y_q, cam_x_q, cam_y_q;
    logic              snap_q, valid_q;
    logic              sel_y;
    logic signed [33:0] tgt, cam, half, max_v, des, err, mag, exc, stp, nxt, clamped;

    // One datapath shared by both axes; the state picks which axis feeds it.
    always_comb begin
        sel_y   = state_q == AXIS_Y;
        tgt     = signed'({2'b00, sel_y ? ty_q : tx_q});
        cam     = signed'({2'b00, sel_y ? cam_y_q : cam_x_q});
        half    = sel_y ? HALF_H : HALF_W;
        max_v   = sel_y ? MAX_Y : MAX_X;
        des     = tgt - half;
        err     = des - cam;
        mag     = err[33] ? -err : err;
        // Easing works on the magnitude so both directions step identically;
        // a non-zero step is forced once outside the deadzone.
        exc     = (mag - DZ) >>> SHIFT;
        stp     = (exc == '0) ? 34'sd1 : exc;
        nxt     = snap_q ? des : (mag <= DZ) ? cam : err[33] ? cam - stp : cam + stp;
        clamped = nxt[33] ? '0 : (nxt > max_v) ? max_v : nxt;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = nf_in ? CAPTURE : IDLE;
            CAPTURE: state_d = freeze_in ? COMMIT : AXIS_X;
            AXIS_X:  state_d = AXIS_Y;
            AXIS_Y:  state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tx_q     <= '0;
            ty_q     <= '0;
            snap_q   <= 1'b0;
            hold_x_q <= '0;
            hold_y_q <= '0;
            cam_x_q  <= '0;
            cam_y_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= state_q == COMMIT;
            if (state_q == CAPTURE) begin
                tx_q   <= target_x_in;
                ty_q   <= target_y_in;
                snap_q <= snap_in;
                // A frozen update commits the current position unchanged.
                if (freeze_in) begin
                    hold_x_q <= cam_x_q;
                    hold_y_q <= cam_y_q;
                end
            end
            if (state_q == AXIS_X) hold_x_q <= clamped[31:0];
            if (state_q == AXIS_Y) hold_y_q <= clamped[31:0];
            if (state_q == COMMIT) begin
                cam_x_q <= hold_x_q;
                cam_y_q <= hold_y_q;
            end
        end
    end

    always_comb begin
        camera_x_out = cam_x_q;
        camera_y_out = cam_y_q;
        valid_out    = valid_q;
        busy_out     = state_q != IDLE;
    end
endmodule
